// File: rtl/cnn_bias_relu_512.sv
// Per-output-channel bias-add with saturation and optional ReLU, fed by a channel-major
// conv result stream. Biases are loaded once after reset, then reused for every frame.
module cnn_bias_relu_512 #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IMAGE_WIDTH     = 32,
  parameter int unsigned IMAGE_HEIGHT    = 32,
  parameter int unsigned CHANNEL_NUM_OUT = 512,
  parameter bit          RELU_EN         = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stride2,
  input  logic                  valid_bias_in,
  input  logic [DATA_WIDTH-1:0] bias_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  bias_ready,
  output logic                  frame_done
);

  localparam int unsigned PlaneFull = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned PlaneHalf = (IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2);
  localparam int unsigned PixW      = (PlaneFull > 1) ? $clog2(PlaneFull) : 1;
  localparam int unsigned ChW       = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  localparam logic [PixW-1:0] PixLastFull = PixW'(PlaneFull - 1);
  localparam logic [PixW-1:0] PixLastHalf = PixW'(PlaneHalf - 1);
  localparam logic [ChW-1:0]  ChLast      = ChW'(CHANNEL_NUM_OUT - 1);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e          state_q, state_d;
  logic [ChW-1:0]  load_cnt_q, load_cnt_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic            stride_q, stride_d;

  logic [DATA_WIDTH-1:0] bias_ram [CHANNEL_NUM_OUT];

  logic accept, frame_start, stride_eff, pix_last, ch_last;

  // Stage-1 registers
  logic                  valid_s1_q, last_s1_q;
  logic [DATA_WIDTH-1:0] pxl_s1_q, bias_s1_q;

  // Stage-2 arithmetic
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] sat, result;

  always_comb begin
    accept      = valid_in && (state_q == StRun);
    frame_start = (pix_q == '0) && (ch_q == '0);
    // The first pixel of a frame uses the live stride2 so plane size is fixed from pixel 0.
    stride_eff  = frame_start ? stride2 : stride_q;
    pix_last    = stride_eff ? (pix_q == PixLastHalf) : (pix_q == PixLastFull);
    ch_last     = (ch_q == ChLast);

    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    ch_d       = ch_q;
    pix_d      = pix_q;
    stride_d   = stride_q;

    case (state_q)
      StLoad: begin
        if (valid_bias_in) begin
          if (load_cnt_q == ChLast) begin
            load_cnt_d = '0;
            state_d    = StRun;
          end else begin
            load_cnt_d = load_cnt_q + ChW'(1);
          end
        end
      end
      StRun: begin
        if (valid_in) begin
          if (frame_start) stride_d = stride2;
          if (pix_last) begin
            pix_d = '0;
            ch_d  = ch_last ? '0 : ch_q + ChW'(1);
          end else begin
            pix_d = pix_q + PixW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StLoad;
      load_cnt_q <= '0;
      ch_q       <= '0;
      pix_q      <= '0;
      stride_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      ch_q       <= ch_d;
      pix_q      <= pix_d;
      stride_q   <= stride_d;
    end
  end

  // Bias storage and its read register are not reset; contents survive until reloaded.
  always_ff @(posedge clk) begin
    if ((state_q == StLoad) && valid_bias_in) bias_ram[load_cnt_q] <= bias_in;
    if (accept) bias_s1_q <= bias_ram[ch_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_s1_q <= 1'b0;
      last_s1_q  <= 1'b0;
      pxl_s1_q   <= '0;
    end else begin
      valid_s1_q <= accept;
      last_s1_q  <= accept && pix_last && ch_last;
      if (accept) pxl_s1_q <= pxl_in;
    end
  end

  always_comb begin
    sum = {pxl_s1_q[DATA_WIDTH-1], pxl_s1_q} + {bias_s1_q[DATA_WIDTH-1], bias_s1_q};
    // Overflow when the extra sign bit disagrees with the result sign bit.
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      sat = sum[DATA_WIDTH-1:0];
    end
    result = (RELU_EN && sat[DATA_WIDTH-1]) ? '0 : sat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pxl_out    <= '0;
    end else begin
      valid_out  <= valid_s1_q;
      frame_done <= last_s1_q;
      if (valid_s1_q) pxl_out <= result;
    end
  end

  assign bias_ready = (state_q == StRun);

endmodule

// File: tb/tb_cnn_bias_relu_512.sv
// Bench for cnn_bias_relu_512: directed and random stimulus against a frame-index
// reference model; every output cycle is compared on the falling edge.
module tb_cnn_bias_relu_512;

  localparam int DW   = 16;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int CH   = 4;
  localparam bit RELU = 1'b1;
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stride2 = 1'b0;
  logic          valid_bias_in = 1'b0;
  logic [DW-1:0] bias_in = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic [DW-1:0] pxl_out;
  logic          valid_out, bias_ready, frame_done;

  cnn_bias_relu_512 #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .CHANNEL_NUM_OUT(CH), .RELU_EN(RELU)
  ) dut (
    .clk(clk), .reset(reset), .stride2(stride2), .valid_bias_in(valid_bias_in),
    .bias_in(bias_in), .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(pxl_out),
    .valid_out(valid_out), .bias_ready(bias_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] val;
    bit            last;
  } exp_t;
  exp_t expq[$];

  // Reference model state: bias table, load progress, and pixel index within the frame.
  int mbias[CH];
  int m_load = 0;
  bit m_run = 1'b0;
  int m_k = 0;
  int m_plane = IW * IH;

  function automatic int model_out(int p, int b);
    int s;
    s = p + b;
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    if (RELU && s < 0) s = 0;
    return s;
  endfunction

  function automatic int rnd_val();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic step(input bit vb, input int b, input bit v, input int p, input bit s2);
    exp_t e;
    int   r;
    valid_bias_in = vb;
    bias_in       = b[DW-1:0];
    valid_in      = v;
    pxl_in        = p[DW-1:0];
    stride2       = s2;
    if (v && m_run) begin
      if (m_k == 0) m_plane = s2 ? (IW / 2) * (IH / 2) : IW * IH;
      r      = model_out(p, mbias[m_k / m_plane]);
      e.due  = cyc + 2;
      e.val  = r[DW-1:0];
      e.last = (m_k == m_plane * CH - 1);
      expq.push_back(e);
      m_k = e.last ? 0 : m_k + 1;
    end
    if (vb && !m_run) begin
      mbias[m_load] = b;
      m_load++;
      if (m_load == CH) m_run = 1'b1;
    end
    @(posedge clk);
    #1;
    vectors++;
    assert (bias_ready === m_run) else begin
      miscompares++;
      $error("FAIL bias_ready cyc=%0d got %b exp %b", cyc, bias_ready, m_run);
    end
  endtask

  task automatic do_reset(input int hold);
    valid_bias_in = 1'b0;
    valid_in      = 1'b0;
    reset         = 1'b0;
    #1;
    vectors += 4;
    assert (valid_out === 1'b0) else begin
      miscompares++; $error("FAIL rst_valid_out got %b exp 0", valid_out);
    end
    assert (bias_ready === 1'b0) else begin
      miscompares++; $error("FAIL rst_bias_ready got %b exp 0", bias_ready);
    end
    assert (frame_done === 1'b0) else begin
      miscompares++; $error("FAIL rst_frame_done got %b exp 0", frame_done);
    end
    assert (pxl_out === '0) else begin
      miscompares++; $error("FAIL rst_pxl_out got %0d exp 0", pxl_out);
    end
    expq.delete();
    m_run  = 1'b0;
    m_load = 0;
    m_k    = 0;
    repeat (hold) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic load(input int b0, input int b1, input int b2, input int b3);
    step(1'b1, b0, 1'b0, 0, 1'b0);
    step(1'b1, b1, 1'b0, 0, 1'b0);
    step(1'b1, b2, 1'b0, 0, 1'b0);
    // A pixel on the final write cycle must be dropped.
    step(1'b1, b3, 1'b1, 123, 1'b0);
  endtask

  // Output monitor: exactly one expected entry is due on each output cycle.
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (reset) begin
      ev = (expq.size() > 0) && (expq[0].due == cyc);
      vectors++;
      assert (valid_out === ev) else begin
        miscompares++;
        $error("FAIL valid_out cyc=%0d got %b exp %b", cyc, valid_out, ev);
      end
      if (ev) begin
        e = expq.pop_front();
        vectors += 2;
        assert (pxl_out === e.val) else begin
          miscompares++;
          $error("FAIL pxl_out cyc=%0d got %0d exp %0d", cyc, $signed(pxl_out), $signed(e.val));
        end
        assert (frame_done === e.last) else begin
          miscompares++;
          $error("FAIL frame_done cyc=%0d got %b exp %b", cyc, frame_done, e.last);
        end
      end else begin
        vectors++;
        assert (frame_done === 1'b0) else begin
          miscompares++;
          $error("FAIL frame_done_idle cyc=%0d got %b exp 0", cyc, frame_done);
        end
      end
    end
  end

  initial begin
    #2;
    do_reset(2);

    // Pixels before any bias is loaded produce nothing.
    repeat (3) step(1'b0, 0, 1'b1, rnd_val(), 1'b0);
    load(10, -20, 0, 5);

    // Frame 1: constant pixels, back-to-back.
    repeat (64) step(1'b0, 0, 1'b1, 100, 1'b0);
    repeat (3) step(1'b0, 0, 1'b0, 0, 1'b0);

    // Frame 2: same data, stray bias writes, stride2 toggling after the first pixel.
    step(1'b1, rnd_val(), 1'b1, 100, 1'b0);
    repeat (63) step(1'b1, rnd_val(), 1'b1, 100, 1'($urandom_range(1)));

    // Frame 3: stride2 plane, gapped 1 on / 2 off, stride2 dropped mid-frame.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 0, 1'b1, rnd_val(), (i < 8));
      step(1'b0, 0, 1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b0, 0, 1'b0);
    end

    // Random traffic spanning several frames.
    repeat (300) step(1'($urandom_range(1)), rnd_val(), 1'($urandom_range(1)), rnd_val(),
                      1'($urandom_range(1)));

    // Reset partway through a frame, then reload and restart at channel 0.
    step(1'b0, 0, 1'b0, 0, 1'b0);
    while (m_k != 0) step(1'b0, 0, 1'b1, rnd_val(), 1'b0);
    repeat (20) step(1'b0, 0, 1'b1, rnd_val(), 1'b0);
    do_reset(3);
    load(1, 2, 3, 4);
    step(1'b0, 0, 1'b1, 7, 1'b0);
    repeat (10) step(1'b0, 0, 1'b1, rnd_val(), 1'b0);

    // Saturation and ReLU corners on a stride2 plane.
    do_reset(2);
    load(32000, -32000, -20, 7);
    step(1'b0, 0, 1'b1, 1000, 1'b1);
    step(1'b0, 0, 1'b1, 32767, 1'b1);
    step(1'b0, 0, 1'b1, -32768, 1'b1);
    step(1'b0, 0, 1'b1, 767, 1'b1);
    step(1'b0, 0, 1'b1, -32768, 1'b1);
    step(1'b0, 0, 1'b1, 32767, 1'b1);
    step(1'b0, 0, 1'b1, -1000, 1'b1);
    step(1'b0, 0, 1'b1, 32000, 1'b1);
    step(1'b0, 0, 1'b1, 5, 1'b1);
    step(1'b0, 0, 1'b1, 20, 1'b1);
    step(1'b0, 0, 1'b1, 19, 1'b1);
    step(1'b0, 0, 1'b1, -32768, 1'b1);
    repeat (4) step(1'b0, 0, 1'b1, rnd_val(), 1'b1);
    repeat (150) step(1'b0, 0, 1'($urandom_range(1)), rnd_val(), 1'($urandom_range(1)));

    repeat (4) step(1'b0, 0, 1'b0, 0, 1'b0);
    vectors++;
    assert (expq.size() == 0) else begin
      miscompares++;
      $error("FAIL drain outstanding=%0d exp 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
